// File: rtl/icache_downstream_linefill_responder_if.sv
// Linefill request (txreq) and cacheline response (rxdat) channels between an icache MSHR and its downstream.
// Both channels use valid/ready handshakes; the payload is {opcode, entry_idx, txnid, data}.
interface icache_downstream_linefill_responder_if #(
  parameter int ADDR_WIDTH             = 32,
  parameter int MSHR_ENTRY_INDEX_WIDTH = 2,
  parameter int ICACHE_REQ_TXNID_WIDTH = 4,
  parameter int OPCODE_WIDTH           = 3,
  parameter int ICACHE_DATA_WIDTH      = 512
);
  localparam int PLD_WIDTH = OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH + ICACHE_REQ_TXNID_WIDTH + ICACHE_DATA_WIDTH;

  logic                              downstream_txreq_vld;
  logic                              downstream_txreq_rdy;
  logic [ADDR_WIDTH-1:0]             downstream_txreq_addr;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] downstream_txreq_entry_idx;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] downstream_txreq_txnid;
  logic [OPCODE_WIDTH-1:0]           downstream_txreq_opcode;
  logic                              downstream_rxdat_vld;
  logic                              downstream_rxdat_rdy;
  logic [PLD_WIDTH-1:0]              downstream_rxdat_pld;

  modport master (
    output downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_entry_idx,
           downstream_txreq_txnid, downstream_txreq_opcode, downstream_rxdat_rdy,
    input  downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld
  );

  modport slave (
    input  downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_entry_idx,
           downstream_txreq_txnid, downstream_txreq_opcode, downstream_rxdat_rdy,
    output downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld
  );
endinterface

// File: rtl/icache_downstream_linefill_responder.sv
// Stand-in L2 for icache misses: queues linefill requests in order and returns one address-derived line each,
// earliest LATENCY cycles after accept; rxdat stalls hold the head, a full queue deasserts txreq_rdy.
module icache_downstream_linefill_responder #(
  parameter int DEPTH                  = 4,
  parameter int LATENCY                = 8,
  parameter int ADDR_WIDTH             = 32,
  parameter int MSHR_ENTRY_INDEX_WIDTH = 2,
  parameter int ICACHE_REQ_TXNID_WIDTH = 4,
  parameter int OPCODE_WIDTH           = 3,
  parameter int ICACHE_DATA_WIDTH      = 512
) (
  input logic                                   clk,
  input logic                                   rst_n,
  icache_downstream_linefill_responder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFS   = $clog2(ICACHE_DATA_WIDTH / 8);
  localparam int WORDS = ICACHE_DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << OFS) - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]             addr;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [OPCODE_WIDTH-1:0]           opcode;
  } req_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]           opcode;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [ICACHE_DATA_WIDTH-1:0]      data;
  } rxdat_t;

  req_t             r_req [DEPTH];
  logic [7:0]       r_cd  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  req_t                         w_in;
  req_t                         w_head;
  logic                         w_txreq_rdy;
  logic                         w_rxdat_vld;
  logic                         w_push;
  logic                         w_pop;
  logic [ADDR_WIDTH-1:0]        w_base;
  logic [ICACHE_DATA_WIDTH-1:0] w_data;
  rxdat_t                       w_pld;

  assign w_in = {bus.downstream_txreq_addr, bus.downstream_txreq_entry_idx,
                 bus.downstream_txreq_txnid, bus.downstream_txreq_opcode};
  assign w_head = r_req[r_rd_ptr];

  // Ready looks only at registered occupancy, so a full queue never accepts even while the head pops.
  assign w_txreq_rdy = (r_count < CNT_W'(DEPTH));
  assign w_rxdat_vld = (r_count != '0) && (r_cd[r_rd_ptr] == 8'd0);
  assign w_push      = bus.downstream_txreq_vld && w_txreq_rdy;
  assign w_pop       = w_rxdat_vld && bus.downstream_rxdat_rdy;

  always_comb begin
    w_base = w_head.addr & ~OFS_MASK;
    w_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_data[32*i +: 32] = 32'(w_base) + 32'(4 * i);
    end
  end

  always_comb begin
    w_pld = '0;
    if (w_rxdat_vld) begin
      w_pld.opcode    = w_head.opcode;
      w_pld.entry_idx = w_head.entry_idx;
      w_pld.txnid     = w_head.txnid;
      w_pld.data      = w_data;
    end
  end

  assign bus.downstream_txreq_rdy = w_txreq_rdy;
  assign bus.downstream_rxdat_vld = w_rxdat_vld;
  assign bus.downstream_rxdat_pld = w_pld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_req[i] <= '0;
        r_cd[i]  <= '0;
      end
    end else begin
      // Countdowns run for every entry, so entries waiting behind the head mature in parallel.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_req[i] <= w_in;
          r_cd[i]  <= 8'(LATENCY - 1);
        end else if (r_cd[i] != 8'd0) begin
          r_cd[i] <= r_cd[i] - 8'd1;
        end
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  a_txreq_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.downstream_txreq_vld && !w_txreq_rdy) |=> (bus.downstream_txreq_vld && $stable(w_in)));

  a_rxdat_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (w_rxdat_vld && !bus.downstream_rxdat_rdy) |=> (w_rxdat_vld && $stable(w_pld)));
endmodule

// File: tb/tb_icache_downstream_linefill_responder.sv
// Bench for the linefill responder: vector table, hand sequences for full/backpressure/reset, random streaming
// checked every cycle against a queue-based reference model.
module tb_icache_downstream_linefill_responder;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 8;
  localparam int AW      = 32;
  localparam int IW      = 2;
  localparam int TW      = 4;
  localparam int OW      = 3;
  localparam int DW      = 512;
  localparam int PLD_W   = OW + IW + TW + DW;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  idx;
    logic [3:0]  txn;
    logic [2:0]  op;
    int          rt;
  } mreq_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  idx;
    logic [3:0]  txn;
    logic [2:0]  op;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;
  bit   stop = 1'b0;
  mreq_t mq[$];
  int    done_cyc[$];

  icache_downstream_linefill_responder_if #(
    .ADDR_WIDTH(AW), .MSHR_ENTRY_INDEX_WIDTH(IW), .ICACHE_REQ_TXNID_WIDTH(TW),
    .OPCODE_WIDTH(OW), .ICACHE_DATA_WIDTH(DW)
  ) bus ();

  icache_downstream_linefill_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_WIDTH(AW), .MSHR_ENTRY_INDEX_WIDTH(IW),
    .ICACHE_REQ_TXNID_WIDTH(TW), .OPCODE_WIDTH(OW), .ICACHE_DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PLD_W-1:0] act, input logic [PLD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference line: opcode/idx/txnid echoed, word i = line base + 4*i.
  function automatic logic [PLD_W-1:0] ref_pld(input mreq_t r);
    logic [DW-1:0] d;
    logic [31:0]   base;
    base = r.addr & 32'hFFFF_FFC0;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = base + 32'(i * 4);
    return {r.op, r.idx, r.txn, d};
  endfunction

  // Model: each request becomes eligible at accept edge + LATENCY; strict FIFO order.
  always @(negedge clk) begin
    logic  e_rdy;
    logic  e_vld;
    mreq_t r;
    if (mon_en && rst_n) begin
      e_rdy = (mq.size() < DEPTH);
      e_vld = (mq.size() > 0) && (mq[0].rt <= cyc + 1);
      chk("txreq_rdy", bus.downstream_txreq_rdy, e_rdy);
      chk("rxdat_vld", bus.downstream_rxdat_vld, e_vld);
      chk("rxdat_pld", bus.downstream_rxdat_pld, e_vld ? ref_pld(mq[0]) : '0);
      if (e_vld && bus.downstream_rxdat_rdy === 1'b1) begin
        void'(mq.pop_front());
        n_done++;
        done_cyc.push_back(cyc + 1);
      end
      if (bus.downstream_txreq_vld === 1'b1 && e_rdy) begin
        r.addr = bus.downstream_txreq_addr;
        r.idx  = bus.downstream_txreq_entry_idx;
        r.txn  = bus.downstream_txreq_txnid;
        r.op   = bus.downstream_txreq_opcode;
        r.rt   = cyc + 1 + LATENCY;
        mq.push_back(r);
        n_acc++;
      end
    end
  end

  // Called just after a rising edge; returns the edge number at which the request was taken.
  task automatic send(input logic [31:0] a, input logic [1:0] idx, input logic [3:0] t,
                      input logic [2:0] op, output int acc_edge);
    logic acc;
    acc = 1'b0;
    acc_edge = -1;
    bus.downstream_txreq_addr      = a;
    bus.downstream_txreq_entry_idx = idx;
    bus.downstream_txreq_txnid     = t;
    bus.downstream_txreq_opcode    = op;
    bus.downstream_txreq_vld       = 1'b1;
    for (int k = 0; k < 200; k++) begin
      acc = bus.downstream_txreq_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_edge = cyc;
        break;
      end
    end
    bus.downstream_txreq_vld = 1'b0;
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic wait_vld(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.downstream_rxdat_vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("wait_vld", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t             tv[4];
    logic [PLD_W-1:0] p;
    logic [PLD_W-1:0] p0;
    int               e;
    int               a0;
    int               d0;
    int               g;

    tv[0] = '{32'h0000_1234, 2'd2, 4'd5,  3'd1, 32'h0000_1200, 32'h0000_1204, 32'h0000_123C};
    tv[1] = '{32'hDEAD_BEEF, 2'd1, 4'd10, 3'd6, 32'hDEAD_BEC0, 32'hDEAD_BEC4, 32'hDEAD_BEFC};
    tv[2] = '{32'hFFFF_FFFF, 2'd3, 4'd15, 3'd7, 32'hFFFF_FFC0, 32'hFFFF_FFC4, 32'hFFFF_FFFC};
    tv[3] = '{32'h0000_0040, 2'd0, 4'd0,  3'd0, 32'h0000_0040, 32'h0000_0044, 32'h0000_007C};

    bus.downstream_txreq_vld       = 1'b0;
    bus.downstream_txreq_addr      = '0;
    bus.downstream_txreq_entry_idx = '0;
    bus.downstream_txreq_txnid     = '0;
    bus.downstream_txreq_opcode    = '0;
    bus.downstream_rxdat_rdy       = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_txreq_rdy", bus.downstream_txreq_rdy, 1'b1);
    chk("reset_rxdat_vld", bus.downstream_rxdat_vld, 1'b0);
    chk("reset_rxdat_pld", bus.downstream_rxdat_pld, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: one request at a time, rdy high, fields and latency checked against hand values.
    bus.downstream_rxdat_rdy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(tv[v].addr, tv[v].idx, tv[v].txn, tv[v].op, e);
      wait_vld(50);
      p = bus.downstream_rxdat_pld;
      chk("vec_latency",   cyc + 1 - e, LATENCY);
      chk("vec_opcode",    p[520:518], tv[v].op);
      chk("vec_entry_idx", p[517:516], tv[v].idx);
      chk("vec_txnid",     p[515:512], tv[v].txn);
      chk("vec_word0",     p[31:0],    tv[v].w0);
      chk("vec_word1",     p[63:32],   tv[v].w1);
      chk("vec_word15",    p[511:480], tv[v].w15);
      @(posedge clk);
      #1;
    end

    // Fill to full, then a pop and a pending request in the same cycle.
    a0 = n_acc;
    d0 = n_done;
    bus.downstream_rxdat_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h1000 + 32'(64 * i), 2'(i), 4'(i + 1), 3'd2, e);
    chk("full_rdy_low", bus.downstream_txreq_rdy, 1'b0);
    bus.downstream_txreq_addr      = 32'h0000_5000;
    bus.downstream_txreq_entry_idx = 2'd3;
    bus.downstream_txreq_txnid     = 4'd9;
    bus.downstream_txreq_opcode    = 3'd4;
    bus.downstream_txreq_vld       = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("full_no_accept", n_acc - a0, 4);
    chk("full_rdy_held", bus.downstream_txreq_rdy, 1'b0);
    wait_vld(20);
    bus.downstream_rxdat_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.downstream_rxdat_rdy = 1'b0;
    chk("pop_cycle_no_push", n_acc - a0, 4);
    chk("pop_cycle_done", n_done - d0, 1);
    chk("rdy_after_pop", bus.downstream_txreq_rdy, 1'b1);
    @(posedge clk);
    #1;
    bus.downstream_txreq_vld = 1'b0;
    chk("push_next_cycle", n_acc - a0, 5);
    chk("refull_rdy_low", bus.downstream_txreq_rdy, 1'b0);
    done_cyc.delete();
    bus.downstream_rxdat_rdy = 1'b1;
    for (int k = 0; k < 60 && (n_done - d0) < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_count", n_done - d0, 5);
    chk("drain_log_size", done_cyc.size(), 4);
    if (done_cyc.size() >= 3) begin
      chk("drain_consec_a", done_cyc[1] - done_cyc[0], 1);
      chk("drain_consec_b", done_cyc[2] - done_cyc[1], 1);
    end
    chk("drained_rdy", bus.downstream_txreq_rdy, 1'b1);
    chk("drained_vld", bus.downstream_rxdat_vld, 1'b0);

    // Backpressure: payload held for 5 stalled cycles, exactly one completion on release.
    bus.downstream_rxdat_rdy = 1'b0;
    send(32'hCAFE_0123, 2'd1, 4'd7, 3'd3, e);
    wait_vld(50);
    p0 = bus.downstream_rxdat_pld;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_vld_high", bus.downstream_rxdat_vld, 1'b1);
      chk("bp_pld_stable", bus.downstream_rxdat_pld, p0);
    end
    d0 = n_done;
    bus.downstream_rxdat_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.downstream_rxdat_rdy = 1'b0;
    chk("bp_one_done", n_done - d0, 1);
    chk("bp_vld_low", bus.downstream_rxdat_vld, 1'b0);

    // Random stream with random rdy: pointers wrap, model checks order and data every cycle.
    a0 = n_acc;
    d0 = n_done;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          g = int'($urandom_range(0, 2));
          repeat (g) begin
            @(posedge clk);
            #1;
          end
          send($urandom, 2'($urandom_range(0, 3)), 4'(i), 3'($urandom_range(0, 7)), e);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          bus.downstream_rxdat_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.downstream_rxdat_rdy = 1'b1;
    for (int k = 0; k < 200 && (n_done - d0) < 10; k++) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_accepted", n_acc - a0, 10);
    chk("wrap_returned", n_done - d0, 10);

    // Reset with requests pending: outputs clear asynchronously, nothing stale afterwards.
    d0 = n_done;
    bus.downstream_rxdat_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h0000_8000 + 32'(i * 64), 2'(i), 4'(12 + i), 3'd5, e);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_vld_low", bus.downstream_rxdat_vld, 1'b0);
    chk("rst_rdy_high", bus.downstream_txreq_rdy, 1'b1);
    chk("rst_pld_zero", bus.downstream_rxdat_pld, '0);
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.downstream_rxdat_rdy = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_stale_resp", n_done - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
